// File: rtl/sdf_node.sv
// sdf_node: dataflow firing node. Grants one flux round-robin when every input
// port has a token on it, reads one token per port, combines the data fields
// with the selected operation and writes the {flux, result} token downstream.
// Build option: define SDF_SAT_EN to make operation 0 a saturating unsigned sum.
module sdf_node #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned FLUX       = 2,
  parameter int unsigned PORTS      = 2,
  parameter int unsigned NUM_OP     = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [1:0]                                    op_sel,
  input  logic [(DATA_WIDTH+$clog2(FLUX))*PORTS-1:0]    dout,
  input  logic [FLUX*PORTS-1:0]                         empty,
  output logic [FLUX*PORTS-1:0]                         read,
  output logic [DATA_WIDTH+$clog2(FLUX)-1:0]            din,
  output logic                                          write,
  input  logic [FLUX-1:0]                               full,
  output logic                                          busy,
  output logic                                          tag_err
);

  localparam int unsigned TAG_W = $clog2(FLUX);
  localparam int unsigned W     = DATA_WIDTH + TAG_W;
`ifdef SDF_SAT_EN
  localparam int unsigned SUM_W = DATA_WIDTH + $clog2(PORTS + 1);
`else
  localparam int unsigned SUM_W = DATA_WIDTH;
`endif

  typedef enum logic [1:0] {IDLE, READ, CAP, WRITE} state_t;

  state_t                  state;
  logic [TAG_W-1:0]        grant;
  logic [TAG_W-1:0]        last_granted;
  logic [TAG_W-1:0]        rr_pick;
  logic [TAG_W-1:0]        cand;
  logic                    rr_found;
  logic [FLUX-1:0]         eligible;
  logic [FLUX*PORTS-1:0]   read_pat;
  logic [DATA_WIDTH-1:0]   tok_data;
  logic [TAG_W-1:0]        tok_tag;
  logic [SUM_W-1:0]        acc_sum;
  logic [DATA_WIDTH-1:0]   acc_and;
  logic [DATA_WIDTH-1:0]   acc_or;
  logic [DATA_WIDTH-1:0]   acc_xor;
  logic [DATA_WIDTH-1:0]   sum_res;
  logic [DATA_WIDTH-1:0]   result;
  logic                    tag_bad;

  // Eligibility per flux and round-robin pick starting after the last grant
  always_comb begin
    eligible = '1;
    for (int p = 0; p < PORTS; p++) begin
      for (int f = 0; f < FLUX; f++) begin
        if (empty[p*FLUX + f]) eligible[f] = 1'b0;
      end
    end
    rr_pick  = '0;
    rr_found = 1'b0;
    cand     = '0;
    for (int i = 1; i <= FLUX; i++) begin
      cand = last_granted + TAG_W'(i);
      if (!rr_found && eligible[cand]) begin
        rr_pick  = cand;
        rr_found = 1'b1;
      end
    end
    read_pat = '0;
    for (int p = 0; p < PORTS; p++) begin
      read_pat[p*FLUX + int'(rr_pick)] = 1'b1;
    end
  end

  // Combine the data fields of all port tokens and flag tags that miss the grant
  always_comb begin
    acc_sum  = '0;
    acc_and  = '1;
    acc_or   = '0;
    acc_xor  = '0;
    tag_bad  = 1'b0;
    tok_data = '0;
    tok_tag  = '0;
    for (int p = 0; p < PORTS; p++) begin
      tok_data = dout[p*W +: DATA_WIDTH];
      tok_tag  = dout[p*W + DATA_WIDTH +: TAG_W];
      acc_sum  = acc_sum + SUM_W'(tok_data);
      acc_and  = acc_and & tok_data;
      acc_or   = acc_or | tok_data;
      acc_xor  = acc_xor ^ tok_data;
      if (tok_tag != grant) tag_bad = 1'b1;
    end
`ifdef SDF_SAT_EN
    sum_res = (acc_sum > SUM_W'({DATA_WIDTH{1'b1}})) ? '1 : DATA_WIDTH'(acc_sum);
`else
    sum_res = acc_sum;
`endif
    result = sum_res;
    if (32'(op_sel) < NUM_OP) begin
      case (op_sel)
        2'd1:    result = acc_and;
        2'd2:    result = acc_or;
        2'd3:    result = acc_xor;
        default: result = sum_res;
      endcase
    end
  end

  // Firing sequence: IDLE grant -> READ strobe -> CAP compute -> WRITE until accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      din          <= '0;
      read         <= '0;
      busy         <= 1'b0;
      tag_err      <= 1'b0;
      grant        <= '0;
      last_granted <= TAG_W'(FLUX - 1);
    end else begin
      read <= '0;
      case (state)
        IDLE: begin
          if (rr_found) begin
            grant <= rr_pick;
            read  <= read_pat;
            busy  <= 1'b1;
            state <= READ;
          end
        end
        READ: state <= CAP;
        CAP: begin
          din <= {grant, result};
          if (tag_bad) tag_err <= 1'b1;
          state <= WRITE;
        end
        WRITE: begin
          if (!full[grant]) begin
            last_granted <= grant;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write strobe follows the granted flux's full flag directly
  assign write = (state == WRITE) && !full[grant];

endmodule

// File: tb/tb_sdf_node.sv
// Scoreboard bench for sdf_node: FIFO models on every port/flux, random token
// arrival, random output back-pressure, and a reference model of grant order,
// firing timing and token arithmetic.
module tb_sdf_node;

  localparam int DW     = 4;
  localparam int FLUX   = 2;
  localparam int PORTS  = 2;
  localparam int NUM_OP = 3;
  localparam int TW     = $clog2(FLUX);
  localparam int W      = DW + TW;
  localparam int PF     = PORTS * FLUX;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        op_sel = 2'd0;
  logic [W*PORTS-1:0] dout = '0;
  logic [PF-1:0]     empty = '1;
  logic [PF-1:0]     read;
  logic [W-1:0]      din;
  logic              write;
  logic [FLUX-1:0]   full = '0;
  logic              busy;
  logic              tag_err;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] fq [PF][$];
  logic [W-1:0] sb [$];
  bit feed = 1'b0;
  bit full_rand = 1'b1;

  sdf_node #(.DATA_WIDTH(DW), .FLUX(FLUX), .PORTS(PORTS), .NUM_OP(NUM_OP)) dut (
    .clk(clk), .rst(rst), .op_sel(op_sel), .dout(dout), .empty(empty),
    .read(read), .din(din), .write(write), .full(full), .busy(busy),
    .tag_err(tag_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_op(input int op, input int vals[PORTS]);
    int acc;
    int mx;
    mx = (1 << DW) - 1;
    if (op >= NUM_OP) op = 0;
    acc = 0;
    case (op)
      1: begin acc = mx; foreach (vals[i]) acc = acc & vals[i]; end
      2: begin foreach (vals[i]) acc = acc | vals[i]; end
      3: begin foreach (vals[i]) acc = acc ^ vals[i]; end
      default: begin
        foreach (vals[i]) acc = acc + vals[i];
`ifdef SDF_SAT_EN
        if (acc > mx) acc = mx;
`else
        acc = acc % (mx + 1);
`endif
      end
    endcase
    return DW'(acc);
  endfunction

  // Input FIFOs and output back-pressure
  initial begin
    logic [PF-1:0] rd_s;
    int hold [FLUX];
    fq[0].push_back({TW'(0), DW'(5)});
    fq[2].push_back({TW'(0), DW'(6)});
    fq[0].push_back({TW'(0), DW'(9)});
    fq[2].push_back({TW'(0), DW'(8)});
    fq[0].push_back({TW'(1), DW'(3)});
    fq[2].push_back({TW'(0), DW'(4)});
    foreach (hold[f]) hold[f] = 0;
    for (int i = 0; i < PF; i++) empty[i] = (fq[i].size() == 0);
    forever begin
      @(negedge clk);
      rd_s = read;
      @(posedge clk);
      #1;
      for (int p = 0; p < PORTS; p++) begin
        for (int f = 0; f < FLUX; f++) begin
          if (rd_s[p*FLUX+f] && fq[p*FLUX+f].size() > 0)
            dout[p*W +: W] = fq[p*FLUX+f].pop_front();
        end
      end
      if (feed) begin
        for (int i = 0; i < PF; i++) begin
          if (fq[i].size() < 6 && $urandom_range(0, 9) == 0) begin
            int f;
            f = i % FLUX;
            if ($urandom_range(0, 15) == 0) fq[i].push_back({TW'(f + 1), DW'($urandom)});
            else fq[i].push_back({TW'(f), DW'($urandom)});
          end
        end
      end
      for (int f = 0; f < FLUX; f++) begin
        if (!full_rand) begin
          hold[f] = 0;
          full[f] = 1'b0;
        end else if (hold[f] > 0) begin
          hold[f]--;
          full[f] = 1'b1;
        end else if ($urandom_range(0, 7) == 0) begin
          hold[f] = $urandom_range(1, 6);
          full[f] = 1'b1;
        end else begin
          full[f] = 1'b0;
        end
      end
      for (int i = 0; i < PF; i++) empty[i] = (fq[i].size() == 0);
    end
  end

  // Reference model of firing order/timing plus scoreboard checking
  initial begin
    int cyc, rd_cyc, g, last;
    bit active, exp_tag, bad, ew;
    logic [PF-1:0] pat;
    int dir_ops [$];
    int vals [PORTS];
    cyc = 0; rd_cyc = -10; g = 0; last = FLUX - 1;
    active = 0; exp_tag = 0; bad = 0; pat = '0;
    dir_ops.push_back(0);
    dir_ops.push_back(3);
    forever begin
      @(negedge clk);
      cyc++;
      chk("read", 32'(read), (active && cyc == rd_cyc) ? 32'(pat) : 32'd0);
      chk("busy", 32'(busy), 32'(active && cyc >= rd_cyc));
      if (active && cyc >= rd_cyc + 2) exp_tag = exp_tag | bad;
      chk("tag_err", 32'(tag_err), 32'(exp_tag));
      ew = active && cyc >= rd_cyc + 2 && !full[g];
      chk("write", 32'(write), 32'(ew));
      if (active && cyc >= rd_cyc + 2 && sb.size() > 0) chk("din", 32'(din), 32'(sb[0]));
      if (rst) begin
        active = 0; sb.delete(); last = FLUX - 1; exp_tag = 0; bad = 0;
      end else if (active) begin
        if (ew) begin
          void'(sb.pop_front());
          active = 0;
          last = g;
          if (dir_ops.size() > 0) op_sel = 2'(dir_ops.pop_front());
          else op_sel = 2'($urandom_range(0, 3));
        end
      end else begin
        bit found;
        found = 0;
        for (int i = 1; i <= FLUX && !found; i++) begin
          int f;
          bit e;
          f = (last + i) % FLUX;
          e = 1;
          for (int p = 0; p < PORTS; p++) if (fq[p*FLUX+f].size() == 0) e = 0;
          if (e) begin g = f; found = 1; end
        end
        if (found) begin
          active = 1;
          rd_cyc = cyc + 1;
          pat = '0;
          bad = 0;
          for (int p = 0; p < PORTS; p++) begin
            logic [W-1:0] t;
            t = fq[p*FLUX+g][0];
            pat[p*FLUX+g] = 1'b1;
            vals[p] = int'(t[DW-1:0]);
            if (int'(t[W-1:DW]) != g) bad = 1;
          end
          sb.push_back({TW'(g), ref_op(int'(op_sel), vals)});
        end
      end
    end
  end

  // Reset sequencing, phases and summary
  initial begin
    bit seen;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_din", 32'(din), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_read", 32'(read), 32'd0);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_tag_err", 32'(tag_err), 32'd0);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    feed = 1'b1;
    repeat (2000) @(posedge clk);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (read != '0) seen = 1;
    end
    chk("read_seen", 32'(seen), 32'd1);
    if (seen) begin
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("cap_rst_din", 32'(din), 32'd0);
      chk("cap_rst_busy", 32'(busy), 32'd0);
      chk("cap_rst_read", 32'(read), 32'd0);
      chk("cap_rst_write", 32'(write), 32'd0);
      chk("cap_rst_tag_err", 32'(tag_err), 32'd0);
      rst = 1'b0;
    end
    repeat (500) @(posedge clk);
    #1;
    feed = 1'b0;
    full_rand = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
